// File: rtl/imem_pkg.sv
// +--------------------------------------------------------------------------+
// | imem_pkg : shared constants, FSM encoding and response entry layout      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package imem_pkg;

  localparam int XLEN       = 32;
  localparam int FIFO_DEPTH = 2;
  localparam int ENTRY_W    = 1 + 2 * XLEN;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_e;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } rsp_entry_t;

endpackage

`default_nettype wire

// File: rtl/imem_rsp_fifo.sv
// +--------------------------------------------------------------------------+
// | imem_rsp_fifo : 2-entry fall-through response FIFO with flush            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module imem_rsp_fifo
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_entry_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic               valid_o,
  output logic [ENTRY_W-1:0] head_o,
  output logic [1:0]         count_o
);

  fifo_state_e        state_q, state_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic               empty;
  logic               do_pop;
  logic               bypass;
  logic               wr_en;
  logic               rd_adv;

  // When empty the incoming entry is presented directly so a fresh read
  // reaches the consumer one cycle after acceptance.
  assign empty   = (state_q == ST_EMPTY);
  assign valid_o = !empty || push_i;
  assign head_o  = empty ? push_entry_i : mem_q[rd_ptr_q];
  assign do_pop  = pop_i && valid_o;
  assign bypass  = empty && push_i && do_pop;
  assign wr_en   = push_i && !bypass && !flush_i;
  assign rd_adv  = do_pop && !empty && !flush_i;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (wr_en) state_d = ST_ONE;
        ST_ONE: begin
          if (wr_en && !rd_adv)      state_d = ST_FULL;
          else if (!wr_en && rd_adv) state_d = ST_EMPTY;
        end
        ST_FULL:  if (!wr_en && rd_adv) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    count_o = 2'd0;
    case (state_q)
      ST_ONE:  count_o = 2'd1;
      ST_FULL: count_o = 2'd2;
      default: count_o = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (wr_en)  wr_ptr_q <= ~wr_ptr_q;
        if (rd_adv) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Push while full and popping reuses the slot being vacated this edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

`default_nettype wire

// File: rtl/imem_responder.sv
// +--------------------------------------------------------------------------+
// | imem_responder : instruction memory with read stage and response FIFO    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module imem_responder
  import imem_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            req_flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [XLEN-1:0] rsp_addr,
  output logic            rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0]    mem_q [DEPTH];
  logic               rd_vld_q, rd_vld_d;
  logic [XLEN-1:0]    rd_addr_q, rd_addr_d;
  logic               rd_err_q, rd_err_d;
  logic [XLEN-1:0]    rd_data_q;
  logic [29:0]        req_idx;
  logic               req_err;
  logic               accept;
  logic [1:0]         fifo_count;
  logic               fifo_valid;
  logic [ENTRY_W-1:0] fifo_head;
  rsp_entry_t         head;

  // Full 30-bit word index compare so high addresses never alias low words.
  assign req_idx   = req_addr[31:2];
  assign req_err   = (req_addr[1:0] != 2'b00) || ({2'b00, req_idx} >= 32'(DEPTH));
  assign req_ready = !reset && !req_flush &&
                     ((3'(fifo_count) + 3'(rd_vld_q)) < 3'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;

  always_comb begin
    rd_vld_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_err_d  = rd_err_q;
    if (accept) begin
      rd_vld_d  = 1'b1;
      rd_addr_d = req_addr;
      rd_err_d  = req_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      rd_addr_q <= rd_addr_d;
      rd_err_q  <= rd_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                   rd_data_q <= '0;
    else if (accept && !req_err) rd_data_q <= mem_q[req_idx[AW-1:0]];
    else if (accept)             rd_data_q <= NOP_INSTR;
  end

  imem_rsp_fifo u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (rd_vld_q),
    .push_entry_i ({rd_err_q, rd_addr_q, rd_data_q}),
    .pop_i        (rsp_ready && !req_flush && !reset),
    .flush_i      (req_flush),
    .valid_o      (fifo_valid),
    .head_o       (fifo_head),
    .count_o      (fifo_count)
  );

  assign head      = rsp_entry_t'(fifo_head);
  assign rsp_valid = fifo_valid && !req_flush && !reset;
  assign rsp_data  = head.data;
  assign rsp_addr  = head.addr;
  assign rsp_err   = head.err;

endmodule

`default_nettype wire
